hyperbus_trans_arbiter: RTL and testbench

HYPERBUS_TRANS_ARBITER -- requirements
Module: hyperbus_trans_arbiter

---
 rtl/hyperbus_pkg.sv | 18 +
 rtl/hyperbus_rr_arb.sv | 29 ++
 rtl/hyperbus_trans_arbiter.sv | 133 +++++++++++++
 tb/tb_hyperbus_trans_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus transaction arbiter.
// Index convention: requester 0 is the read path, requester 1 the write path.
package hyperbus_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

   localparam int unsigned REQ_RD = 0;
   localparam int unsigned REQ_WR = 1;

   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/hyperbus_rr_arb.sv
// Two-requester round-robin arbiter; the owner is remembered only when a grant is accepted.
// Reset leaves read as last owner so that write wins the first contested cycle.
module hyperbus_rr_arb
   import hyperbus_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   logic r_last;
   logic w_win;

   // On contention the requester that did not win last time goes first.
   assign w_win = (req_i == 2'b11) ? ~r_last : req_i[REQ_WR];
   assign gnt_o = (|req_i) ? idx_to_onehot(w_win) : 2'b00;

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last <= 1'(REQ_RD);
      end else if (accept_i) begin
         r_last <= w_win;
      end
   end

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Arbitrates the read and write request paths onto a single HyperBus PHY transaction port.
// Optional completion watchdog enabled by defining HYPERBUS_TRANS_TIMEOUT_EN.
module hyperbus_trans_arbiter
   import hyperbus_pkg::*;
#(
   parameter int unsigned BURST_WIDTH    = 12,
   parameter int unsigned NR_CS          = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0][31:0]           req_addr_i,
   input  logic [1:0][7:0]            req_len_i,
   input  logic [1:0][1:0]            req_burst_i,
   input  logic [1:0][NR_CS-1:0]      req_cs_i,
   input  logic [1:0]                 done_i,
   output logic                       trans_valid_o,
   input  logic                       trans_ready_i,
   output logic [31:0]                trans_address_o,
   output logic [NR_CS-1:0]           trans_cs_o,
   output logic                       trans_write_o,
   output logic [BURST_WIDTH-1:0]     trans_burst_o,
   output logic                       trans_burst_type_o,
   output logic                       trans_address_space_o,
   output logic [1:0]                 grant_o,
   output logic                       busy_o,
   output logic                       timeout_o
);

   state_e                 r_state, w_state_nxt;
   logic                   r_idx;
   logic [31:0]            r_addr;
   logic [NR_CS-1:0]       r_cs;
   logic [BURST_WIDTH-1:0] r_burst;
   logic                   r_burst_type;
   logic                   r_addr_space;

   logic [1:0]             w_arb_gnt;
   logic                   w_win_idx;
   logic                   w_accept;
   logic                   w_done;
   logic                   w_timeout_hit;

   hyperbus_rr_arb u_rr_arb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req_valid_i),
      .accept_i (w_accept),
      .gnt_o    (w_arb_gnt)
   );

   assign w_win_idx = w_arb_gnt[REQ_WR];
   assign w_accept  = (r_state == IDLE) && (|req_valid_i);
   assign w_done    = done_i[r_idx];

`ifdef HYPERBUS_TRANS_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_timeout;

   // The counter holds the index of the current WAIT_DONE cycle, starting at 0 on entry.
   assign w_timeout_hit = (r_state == WAIT_DONE) && !w_done &&
                          (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= w_timeout_hit;
         if (r_state == ISSUE && trans_ready_i) begin
            r_wait_cnt <= '0;
         end else if (r_state == WAIT_DONE) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         end
      end
   end

   assign timeout_o = r_timeout;
`else
   assign w_timeout_hit = 1'b0;
   assign timeout_o     = 1'b0;
`endif

   always_comb begin
      // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:      if (w_accept) w_state_nxt = ISSUE;
         ISSUE:     if (trans_ready_i) w_state_nxt = WAIT_DONE;
         WAIT_DONE: if (w_done || w_timeout_hit) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_idx        <= 1'b0;
         r_addr       <= '0;
         r_cs         <= '0;
         r_burst      <= '0;
         r_burst_type <= 1'b0;
         r_addr_space <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_idx        <= w_win_idx;
            r_addr       <= req_addr_i[w_win_idx];
            r_cs         <= req_cs_i[w_win_idx];
            r_burst      <= BURST_WIDTH'(req_len_i[w_win_idx]) + BURST_WIDTH'(1);
            r_burst_type <= req_burst_i[w_win_idx][0];
            r_addr_space <= req_addr_i[w_win_idx][31];
         end
      end
   end

   // Ready is combinational from the request, so it is also masked while reset is held.
   assign req_ready_o           = (w_accept && rst_ni) ? w_arb_gnt : 2'b00;
   assign trans_valid_o         = (r_state == ISSUE);
   assign busy_o                = (r_state != IDLE);
   assign grant_o               = busy_o ? idx_to_onehot(r_idx) : 2'b00;
   assign trans_address_o       = r_addr;
   assign trans_cs_o            = r_cs;
   assign trans_write_o         = r_idx;
   assign trans_burst_o         = r_burst;
   assign trans_burst_type_o    = r_burst_type;
   assign trans_address_space_o = r_addr_space;

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Self-checking bench for hyperbus_trans_arbiter: directed table, multi-cycle corner cases
// and a randomized run against a transaction-level reference model.
module tb_hyperbus_trans_arbiter;

   localparam int BW  = 12;
   localparam int NCS = 2;
   localparam int TMO = 16;

`ifdef HYPERBUS_TRANS_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic [1:0]            req_valid_i;
   logic [1:0]            req_ready_o;
   logic [1:0][31:0]      req_addr_i;
   logic [1:0][7:0]       req_len_i;
   logic [1:0][1:0]       req_burst_i;
   logic [1:0][NCS-1:0]   req_cs_i;
   logic [1:0]            done_i;
   logic                  trans_valid_o;
   logic                  trans_ready_i;
   logic [31:0]           trans_address_o;
   logic [NCS-1:0]        trans_cs_o;
   logic                  trans_write_o;
   logic [BW-1:0]         trans_burst_o;
   logic                  trans_burst_type_o;
   logic                  trans_address_space_o;
   logic [1:0]            grant_o;
   logic                  busy_o;
   logic                  timeout_o;

   hyperbus_trans_arbiter #(
      .BURST_WIDTH    (BW),
      .NR_CS          (NCS),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .req_valid_i           (req_valid_i),
      .req_ready_o           (req_ready_o),
      .req_addr_i            (req_addr_i),
      .req_len_i             (req_len_i),
      .req_burst_i           (req_burst_i),
      .req_cs_i              (req_cs_i),
      .done_i                (done_i),
      .trans_valid_o         (trans_valid_o),
      .trans_ready_i         (trans_ready_i),
      .trans_address_o       (trans_address_o),
      .trans_cs_o            (trans_cs_o),
      .trans_write_o         (trans_write_o),
      .trans_burst_o         (trans_burst_o),
      .trans_burst_type_o    (trans_burst_type_o),
      .trans_address_space_o (trans_address_space_o),
      .grant_o               (grant_o),
      .busy_o                (busy_o),
      .timeout_o             (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Fixed per-path request fields used by the directed part.
   logic [31:0]    fx_addr  [2] = '{32'h8000_0040, 32'h0000_1000};
   logic [7:0]     fx_len   [2] = '{8'd3, 8'd255};
   logic [1:0]     fx_burst [2] = '{2'b01, 2'b10};
   logic [NCS-1:0] fx_cs    [2] = '{2'b01, 2'b10};

   task automatic set_fixed();
      for (int i = 0; i < 2; i++) begin
         req_addr_i[i]  = fx_addr[i];
         req_len_i[i]   = fx_len[i];
         req_burst_i[i] = fx_burst[i];
         req_cs_i[i]    = fx_cs[i];
      end
   endtask

   task automatic check_fields(input string name, input int owner);
      check({name, "_write"}, 32'(trans_write_o), 32'(owner));
      check({name, "_burst"}, 32'(trans_burst_o), 32'(fx_len[owner]) + 32'd1);
      check({name, "_addr"},  trans_address_o, fx_addr[owner]);
      check({name, "_space"}, 32'(trans_address_space_o), 32'(fx_addr[owner] >> 31));
      check({name, "_btype"}, 32'(trans_burst_type_o), 32'(fx_burst[owner] & 2'b01));
      check({name, "_cs"},    32'(trans_cs_o), 32'(fx_cs[owner]));
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ready"},  32'(req_ready_o), 32'd0);
      check({name, "_tvalid"}, 32'(trans_valid_o), 32'd0);
      check({name, "_grant"},  32'(grant_o), 32'd0);
      check({name, "_busy"},   32'(busy_o), 32'd0);
      check({name, "_tmo"},    32'(timeout_o), 32'd0);
      check({name, "_addr"},   trans_address_o, 32'd0);
      check({name, "_cs"},     32'(trans_cs_o), 32'd0);
      check({name, "_write"},  32'(trans_write_o), 32'd0);
      check({name, "_burst"},  32'(trans_burst_o), 32'd0);
      check({name, "_btype"},  32'(trans_burst_type_o), 32'd0);
      check({name, "_space"},  32'(trans_address_space_o), 32'd0);
   endtask

   task automatic drive(input logic [1:0] v, input logic t, input logic [1:0] d);
      req_valid_i   = v;
      trans_ready_i = t;
      done_i        = d;
      #1;
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   typedef struct {
      logic [1:0] valid;
      logic       trdy;
      logic [1:0] done;
      logic [1:0] e_ready;
      logic       e_tvalid;
      logic [1:0] e_grant;
      logic       e_busy;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] v, input logic t, input logic [1:0] d,
                               input logic [1:0] er, input logic ev, input logic [1:0] eg,
                               input logic eb);
      mk = '{v, t, d, er, ev, eg, eb};
   endfunction

   vec_t tbl[18];

   // Transaction-level reference model state.
   typedef struct {
      logic [31:0]    addr;
      logic [NCS-1:0] cs;
      logic           write;
      logic [31:0]    burst;
      logic           btype;
      logic           space;
   } txn_t;

   txn_t m_txn;
   bit   m_open;
   bit   m_phy_took;
   bit   m_tmo;
   int   m_last;
   int   m_waited;

   initial begin
      rst_ni        = 1'b0;
      req_valid_i   = '0;
      trans_ready_i = 1'b0;
      done_i        = '0;
      set_fixed();

      //              valid  trdy  done   ready  tval  grant  busy
      tbl[0]  = mk(2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0);
      tbl[1]  = mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1);
      tbl[2]  = mk(2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1);
      tbl[3]  = mk(2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 2'b01, 1'b1);
      tbl[4]  = mk(2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1);
      tbl[5]  = mk(2'b11, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0);
      tbl[6]  = mk(2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1);
      tbl[7]  = mk(2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1);
      tbl[8]  = mk(2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 2'b10, 1'b1);
      tbl[9]  = mk(2'b01, 1'b0, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1);
      tbl[10] = mk(2'b11, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0);
      tbl[11] = mk(2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1);
      tbl[12] = mk(2'b10, 1'b0, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1);
      tbl[13] = mk(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0);
      tbl[14] = mk(2'b00, 1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1);
      tbl[15] = mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1);
      tbl[16] = mk(2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1);
      tbl[17] = mk(2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0);

      // Reset state.
      repeat (2) tick();
      #1;
      check_all_zero("reset");
      tick();
      rst_ni = 1'b1;

      // Directed table: single read, ignored done pulses, round-robin alternation.
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].valid, tbl[i].trdy, tbl[i].done);
         check($sformatf("tbl%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].e_ready));
         check($sformatf("tbl%0d_tvalid", i), 32'(trans_valid_o), 32'(tbl[i].e_tvalid));
         check($sformatf("tbl%0d_grant", i), 32'(grant_o), 32'(tbl[i].e_grant));
         check($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
         check($sformatf("tbl%0d_tmo", i), 32'(timeout_o), 32'd0);
         if (tbl[i].e_busy) check_fields($sformatf("tbl%0d", i), int'(tbl[i].e_grant[1]));
         tick();
      end

      // PHY stall: request and fields hold for six cycles, nothing else is accepted.
      drive(2'b01, 1'b0, 2'b00);
      check("stall_accept", 32'(req_ready_o), 32'b01);
      tick();
      for (int k = 0; k < 6; k++) begin
         drive(2'b11, (k == 5), 2'b00);
         check("stall_tvalid", 32'(trans_valid_o), 32'd1);
         check("stall_ready", 32'(req_ready_o), 32'd0);
         check_fields("stall", 0);
         tick();
      end
      drive(2'b00, 1'b0, 2'b01);
      check("stall_wait_busy", 32'(busy_o), 32'd1);
      tick();
      drive(2'b00, 1'b0, 2'b00);
      check("stall_idle_busy", 32'(busy_o), 32'd0);
      tick();

      // Asynchronous reset while a write is outstanding restores write priority.
      drive(2'b10, 1'b0, 2'b00);
      check("rst_pre_accept", 32'(req_ready_o), 32'b10);
      tick();
      drive(2'b00, 1'b1, 2'b00);
      tick();
      drive(2'b11, 1'b0, 2'b00);
      check("rst_pre_grant", 32'(grant_o), 32'b10);
      rst_ni = 1'b0;
      #1;
      check_all_zero("rst_mid");
      tick();
      rst_ni = 1'b1;
      drive(2'b11, 1'b0, 2'b00);
      check("rr_first_wr", 32'(req_ready_o), 32'b10);
      tick();
      drive(2'b11, 1'b1, 2'b00);
      check("rr_first_write_o", 32'(trans_write_o), 32'd1);
      tick();
      drive(2'b11, 1'b0, 2'b10);
      tick();
      drive(2'b11, 1'b0, 2'b00);
      check("rr_then_rd", 32'(req_ready_o), 32'b01);
      tick();
      drive(2'b11, 1'b1, 2'b00);
      check("rr_then_write_o", 32'(trans_write_o), 32'd0);
      tick();
      drive(2'b11, 1'b0, 2'b01);
      tick();
      drive(2'b11, 1'b0, 2'b00);
      check("rr_again_wr", 32'(req_ready_o), 32'b10);
      tick();
      drive(2'b00, 1'b1, 2'b00);
      tick();
      drive(2'b00, 1'b0, 2'b10);
      tick();

      // Completion never arrives: watchdog fires after TMO cycles, or the wait is indefinite.
      drive(2'b01, 1'b0, 2'b00);
      check("wd_accept", 32'(req_ready_o), 32'b01);
      tick();
      drive(2'b00, 1'b1, 2'b00);
      tick();
      for (int j = 0; j < 20; j++) begin
         drive(2'b00, 1'b0, 2'b00);
         check($sformatf("wd_tmo_j%0d", j), 32'(timeout_o), TMO_EN ? 32'(j == TMO) : 32'd0);
         check($sformatf("wd_busy_j%0d", j), 32'(busy_o), TMO_EN ? 32'(j < TMO) : 32'd1);
         tick();
      end
      drive(2'b00, 1'b0, 2'b01);
      tick();
      drive(2'b00, 1'b0, 2'b00);
      check("wd_end_idle", 32'(busy_o), 32'd0);

      // Randomized run against the reference model, starting from a fresh reset.
      rst_ni = 1'b0;
      #1;
      tick();
      rst_ni     = 1'b1;
      m_txn      = '{addr: '0, cs: '0, write: 1'b0, burst: '0, btype: 1'b0, space: 1'b0};
      m_open     = 1'b0;
      m_phy_took = 1'b0;
      m_tmo      = 1'b0;
      m_last     = 0;
      m_waited   = 0;
      for (int n = 0; n < 600; n++) begin
         int   winner;
         int   owner;
         bit   tmo_next;
         for (int i = 0; i < 2; i++) begin
            req_addr_i[i]  = $urandom;
            req_len_i[i]   = 8'($urandom_range(0, 255));
            req_burst_i[i] = 2'($urandom_range(0, 3));
            req_cs_i[i]    = NCS'(1) << $urandom_range(0, NCS - 1);
         end
         drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});

         winner = (req_valid_i == 2'b11) ? (1 - m_last) : (req_valid_i == 2'b10 ? 1 : 0);
         owner  = int'(m_txn.write);
         check("rnd_ready", 32'(req_ready_o),
               (!m_open && req_valid_i != 2'b00) ? (32'd1 << winner) : 32'd0);
         check("rnd_tvalid", 32'(trans_valid_o), 32'(m_open && !m_phy_took));
         check("rnd_grant", 32'(grant_o), m_open ? (32'd1 << owner) : 32'd0);
         check("rnd_busy", 32'(busy_o), 32'(m_open));
         check("rnd_tmo", 32'(timeout_o), 32'(m_tmo));
         check("rnd_write", 32'(trans_write_o), 32'(m_txn.write));
         check("rnd_burst", 32'(trans_burst_o), m_txn.burst);
         check("rnd_addr", trans_address_o, m_txn.addr);
         check("rnd_cs", 32'(trans_cs_o), 32'(m_txn.cs));
         check("rnd_btype", 32'(trans_burst_type_o), 32'(m_txn.btype));
         check("rnd_space", 32'(trans_address_space_o), 32'(m_txn.space));

         tmo_next = 1'b0;
         if (!m_open) begin
            if (req_valid_i != 2'b00) begin
               m_txn.addr  = req_addr_i[winner];
               m_txn.cs    = req_cs_i[winner];
               m_txn.write = 1'(winner);
               m_txn.burst = 32'(req_len_i[winner]) + 32'd1;
               m_txn.btype = req_burst_i[winner][0];
               m_txn.space = req_addr_i[winner][31];
               m_open      = 1'b1;
               m_phy_took  = 1'b0;
               m_last      = winner;
            end
         end else if (!m_phy_took) begin
            if (trans_ready_i) begin
               m_phy_took = 1'b1;
               m_waited   = 0;
            end
         end else if (done_i[owner]) begin
            m_open = 1'b0;
         end else if (TMO_EN) begin
            m_waited++;
            if (m_waited == TMO) begin
               m_open   = 1'b0;
               tmo_next = 1'b1;
            end
         end
         m_tmo = tmo_next;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
